// File: rtl/vector_dot_lanes.sv
// vector_dot_lanes: LANES-wide signed dot product per row, S1 multiply / S2 reduce / S3 accumulate.
// Optional macro SATURATE_EN: saturating accumulation with a sticky per-row overflow flag on tuser.
module vector_dot_lanes #(
  parameter int LANES          = 4,
  parameter int DATA_W         = 32,
  parameter int ACC_W          = 80,
  parameter int LEN_W          = 32,
  parameter int LEN_FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [LANES*DATA_W-1:0] S_AXIS_A_tdata,
  input  logic                    S_AXIS_A_tvalid,
  output logic                    S_AXIS_A_tready,
  input  logic [LANES*DATA_W-1:0] S_AXIS_B_tdata,
  input  logic                    S_AXIS_B_tvalid,
  output logic                    S_AXIS_B_tready,
  input  logic [LEN_W-1:0]        S_AXIS_LEN_tdata,
  input  logic                    S_AXIS_LEN_tvalid,
  output logic                    S_AXIS_LEN_tready,
  output logic [ACC_W-1:0]        M_AXIS_OUT_tdata,
  output logic                    M_AXIS_OUT_tvalid,
  input  logic                    M_AXIS_OUT_tready,
  output logic                    M_AXIS_OUT_tuser,
  output logic [31:0]             rows_done,
  output logic                    busy
);

  localparam int LG  = $clog2(LANES);
  localparam int FAW = (LEN_FIFO_DEPTH > 1) ? $clog2(LEN_FIFO_DEPTH) : 1;
  localparam int PW  = 2 * DATA_W;
  localparam logic [LEN_W-1:0] LANE_MSK = LEN_W'(LANES - 1);
  localparam logic [FAW:0]     PTR_ONE  = (FAW + 1)'(1);

  typedef enum logic {IDLE, RUN} state_t;

`ifdef SATURATE_EN
  // Returns {overflow, result}; clamps toward the sign of the operands on overflow.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [ACC_W-1:0] b);
    logic signed [ACC_W-1:0] s;
    s = a + b;
    if ((a[ACC_W-1] == b[ACC_W-1]) && (s[ACC_W-1] != a[ACC_W-1]))
      return {1'b1, a[ACC_W-1], {(ACC_W-1){~a[ACC_W-1]}}};
    return {1'b0, s};
  endfunction
`else
  function automatic logic signed [ACC_W-1:0] wrap_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W-1:0] b);
    return a + b;
  endfunction
`endif

  state_t                   state_q;
  logic [LEN_W-1:0]         beats_left_q;
  logic [LEN_W-1:0]         rem_q;
  logic [LEN_W-1:0]         len_mem [LEN_FIFO_DEPTH];
  logic [FAW:0]             wr_ptr_q, rd_ptr_q;
  logic                     len_rdy_q;
  logic                     vld_p1_q, last_p1_q;
  logic signed [PW-1:0]     prod_p1_q [LANES];
  logic signed [PW-1:0]     prod_d    [LANES];
  logic                     vld_p2_q, last_p2_q;
  logic signed [ACC_W-1:0]  sum_p2_q, sum_d;
  logic signed [ACC_W-1:0]  acc_q, res_d;
  logic signed [ACC_W-1:0]  out_data_q;
  logic                     out_vld_q;
  logic [31:0]              rows_done_q;

  logic             stall, empty, full, push, pop, pop_zero, accept, last_beat;
  logic [LEN_W-1:0] len_head, len_beats;

  assign stall     = out_vld_q & ~M_AXIS_OUT_tready;
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[FAW] != rd_ptr_q[FAW]) &&
                     (wr_ptr_q[FAW-1:0] == rd_ptr_q[FAW-1:0]);
  assign push      = S_AXIS_LEN_tvalid & S_AXIS_LEN_tready;
  assign len_head  = len_mem[rd_ptr_q[FAW-1:0]];
  assign pop       = (state_q == IDLE) & ~empty & ~stall;
  assign pop_zero  = pop & (len_head == '0);
  assign len_beats = (len_head >> LG) + {{(LEN_W-1){1'b0}}, |(len_head & LANE_MSK)};
  assign last_beat = (beats_left_q == LEN_W'(1));
  assign accept    = (state_q == RUN) & S_AXIS_A_tvalid & S_AXIS_B_tvalid & ~stall;

  assign S_AXIS_A_tready   = S_AXIS_B_tvalid & (state_q == RUN) & ~stall;
  assign S_AXIS_B_tready   = S_AXIS_A_tvalid & (state_q == RUN) & ~stall;
  assign S_AXIS_LEN_tready = len_rdy_q & ~full;
  assign M_AXIS_OUT_tdata  = out_data_q;
  assign M_AXIS_OUT_tvalid = out_vld_q;
  assign rows_done         = rows_done_q;
  assign busy              = ~empty | (state_q == RUN) | vld_p1_q | vld_p2_q | out_vld_q;

  always_ff @(posedge clk) begin
    if (push) len_mem[wr_ptr_q[FAW-1:0]] <= S_AXIS_LEN_tdata;
  end

  // Row sequencer and length FIFO pointers; len_rdy_q keeps LEN tready low through reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      rem_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      len_rdy_q    <= 1'b0;
    end else begin
      len_rdy_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case (state_q)
        IDLE: begin
          if (pop && !pop_zero) begin
            beats_left_q <= len_beats;
            rem_q        <= len_head & LANE_MSK;
            state_q      <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            beats_left_q <= beats_left_q - LEN_W'(1);
            if (last_beat) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    logic signed [PW-1:0] a_w, b_w;
    logic                 lane_mask;
    for (int i = 0; i < LANES; i++) begin
      a_w = {{DATA_W{S_AXIS_A_tdata[i*DATA_W+DATA_W-1]}}, S_AXIS_A_tdata[i*DATA_W +: DATA_W]};
      b_w = {{DATA_W{S_AXIS_B_tdata[i*DATA_W+DATA_W-1]}}, S_AXIS_B_tdata[i*DATA_W +: DATA_W]};
      // Lanes past the row's tail on a short final beat contribute nothing.
      lane_mask = last_beat && (rem_q != '0) && (LEN_W'(i) >= rem_q);
      prod_d[i] = lane_mask ? '0 : a_w * b_w;
    end
  end

  // ---- S1: lane products ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
    end else if (!stall) begin
      vld_p1_q  <= accept | pop_zero;
      last_p1_q <= pop_zero | (accept & last_beat);
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      for (int i = 0; i < LANES; i++)
        prod_p1_q[i] <= pop_zero ? '0 : prod_d[i];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++)
      sum_d = sum_d + ACC_W'(prod_p1_q[i]);
  end

  // ---- S2: reduced beat sum ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
    end else if (!stall) begin
      vld_p2_q  <= vld_p1_q;
      last_p2_q <= last_p1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!stall && vld_p1_q) sum_p2_q <= sum_d;
  end

`ifdef SATURATE_EN
  logic res_ovf_d, ovf_q, user_q;
  always_comb {res_ovf_d, res_d} = sat_add(acc_q, sum_p2_q);
  assign M_AXIS_OUT_tuser = user_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if (vld_p2_q && !stall) begin
      ovf_q <= last_p2_q ? 1'b0 : (ovf_q | res_ovf_d);
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p2_q && !stall && last_p2_q) user_q <= ovf_q | res_ovf_d;
  end
`else
  always_comb res_d = wrap_add(acc_q, sum_p2_q);
  assign M_AXIS_OUT_tuser = 1'b0;
`endif

  // ---- S3: accumulate, publish on last ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q       <= '0;
      out_vld_q   <= 1'b0;
      rows_done_q <= '0;
    end else begin
      if (out_vld_q && M_AXIS_OUT_tready) begin
        out_vld_q   <= 1'b0;
        rows_done_q <= rows_done_q + 32'd1;
      end
      if (vld_p2_q && !stall) begin
        if (last_p2_q) begin
          acc_q     <= '0;
          out_vld_q <= 1'b1;
        end else begin
          acc_q <= res_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p2_q && !stall && last_p2_q) out_data_q <= res_d;
  end

endmodule
